// File: rtl/fan_adder_pipe.sv
// FAN reduction node with valid/ready handshake.
// Picks one active line from each input half, adds the pair when the row ids match,
// and forwards both lines unchanged when they do not.
// An optional register stage sits between the lane muxes and the adder.
module fan_adder_pipe #(
    parameter int DW_DATA  = 32,
    parameter int DW_ROW   = 5,
    parameter int DW_CTRL  = 4,
    parameter int DW_LINE  = DW_DATA + DW_ROW + DW_CTRL,
    parameter int NUM_IN   = 2,
    parameter int PIPE_MUX = 0,
    parameter int SAT      = 0,
    parameter int DW_CNT   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*DW_LINE-1:0] in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DW_LINE-1:0]      out,
    output logic [DW_CNT-1:0]         add_cnt
);
    localparam int HALF = NUM_IN / 2;
    // Bit position where the ctrl field starts: ctrl[0]=start, [1]=end, [3]=active.
    localparam int CB   = DW_DATA + DW_ROW;

    logic [NUM_IN-1:0][DW_LINE-1:0] lines;
    logic [DW_LINE-1:0] line_l, line_r;
    logic               found_l, found_r;
    logic [DW_LINE-1:0] st_l, st_r;
    logic               st_vld;
    logic               out_adv;

    assign lines   = in;
    // The output register frees up when it is empty or being consumed.
    assign out_adv = ~out_valid | out_ready;

    // Lane select: the left half takes its lowest active line and the right half takes its highest.
    // When a half has no active line, it falls back to the line next to the centre.
    always_comb begin
        line_l  = lines[HALF-1];
        found_l = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            if (!found_l && lines[i][DW_LINE-1]) begin
                line_l  = lines[i];
                found_l = 1'b1;
            end
        end
        line_r  = lines[HALF];
        found_r = 1'b0;
        for (int j = NUM_IN - 1; j >= HALF; j--) begin
            if (!found_r && lines[j][DW_LINE-1]) begin
                line_r  = lines[j];
                found_r = 1'b1;
            end
        end
    end

    generate
        if (PIPE_MUX != 0) begin : g_pipe
            logic               s1_vld;
            logic [DW_LINE-1:0] s1_l, s1_r;

            // This stage can load when it is empty or when its content moves on this cycle.
            assign in_ready = ~s1_vld | out_adv;
            assign st_l     = s1_l;
            assign st_r     = s1_r;
            assign st_vld   = s1_vld;

            // Mux-stage register: holds the selected pair for one cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_vld <= 1'b0;
                    s1_l   <= '0;
                    s1_r   <= '0;
                end else if (in_ready) begin
                    s1_vld <= in_valid;
                    if (in_valid) begin
                        s1_l <= line_l;
                        s1_r <= line_r;
                    end
                end
            end
        end else begin : g_comb
            assign in_ready = out_adv;
            assign st_l     = line_l;
            assign st_r     = line_r;
            assign st_vld   = in_valid;
        end
    endgenerate

    logic [DW_DATA:0]    sum_ext;
    logic [DW_DATA-1:0]  sum;
    logic [DW_CTRL-1:0]  res_ctrl;
    logic [DW_LINE-1:0]  result;
    logic [2*DW_LINE-1:0] out_nxt;
    logic                is_add;

    // Adder, overflow clamp, result ctrl encoding and fragment routing.
    always_comb begin
        is_add  = st_l[CB+3] & st_r[CB+3] &
                  (st_l[DW_DATA +: DW_ROW] == st_r[DW_DATA +: DW_ROW]);
        sum_ext = {st_l[DW_DATA-1], st_l[DW_DATA-1:0]} + {st_r[DW_DATA-1], st_r[DW_DATA-1:0]};
        sum     = sum_ext[DW_DATA-1:0];
        // Overflow shows as a disagreement between the two sign-extended top bits.
        if (SAT != 0 && (sum_ext[DW_DATA] ^ sum_ext[DW_DATA-1]))
            sum = sum_ext[DW_DATA] ? {1'b1, {(DW_DATA-1){1'b0}}} : {1'b0, {(DW_DATA-1){1'b1}}};
        case ({st_l[CB], st_r[CB+1]})
            2'b11:   res_ctrl = DW_CTRL'(4'b0100);
            2'b10:   res_ctrl = DW_CTRL'(4'b1001);
            2'b01:   res_ctrl = DW_CTRL'(4'b1010);
            default: res_ctrl = DW_CTRL'(4'b1000);
        endcase
        result = {res_ctrl, st_l[DW_DATA +: DW_ROW], sum};
        if (!is_add)
            out_nxt = {st_r, st_l};
        else if (res_ctrl == DW_CTRL'(4'b1001))
            out_nxt = {result, {DW_LINE{1'b0}}};
        else if (res_ctrl == DW_CTRL'(4'b1010))
            out_nxt = {{DW_LINE{1'b0}}, result};
        else
            out_nxt = {result, result};
    end

    // Output register and add counter: both advance only when a new result is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            add_cnt   <= '0;
        end else if (out_adv) begin
            out_valid <= st_vld;
            if (st_vld) begin
                out <= out_nxt;
                if (is_add)
                    add_cnt <= add_cnt + DW_CNT'(1);
            end
        end
    end
endmodule

// File: tb/tb_fan_adder_pipe.sv
// Bench for fan_adder_pipe.
// u0: NUM_IN=2, wrap-around add, latency 1.
// u1: NUM_IN=8, saturating add, mux pipeline stage, latency 2.
// A queue per instance holds the expected results; each result is compared when the output is accepted.
module tb_fan_adder_pipe;
    localparam int L = 41;

    typedef struct packed {
        logic [2*L-1:0] o;
        logic           add;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, iv0, iv1, ir0, ir1, ov0, ov1, rdy0, rdy1;
    logic [2*L-1:0] in0, out0, out1;
    logic [8*L-1:0] in1;
    logic [15:0]    cnt0, cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int exp_cnt0 = 0, exp_cnt1 = 0;

    fan_adder_pipe #(.NUM_IN(2), .PIPE_MUX(0), .SAT(0)) u0 (
        .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .in(in0),
        .out_valid(ov0), .out_ready(rdy0), .out(out0), .add_cnt(cnt0));

    fan_adder_pipe #(.NUM_IN(8), .PIPE_MUX(1), .SAT(1)) u1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .in(in1),
        .out_valid(ov1), .out_ready(rdy1), .out(out1), .add_cnt(cnt1));

    always @(posedge clk) cyc++;

    function automatic logic [L-1:0] mkline(input logic [3:0] c, input logic [4:0] r, input logic [31:0] d);
        return {c, r, d};
    endfunction

    // Reference model of one node evaluation.
    function automatic void model(input logic [8*L-1:0] bus, input int n, input bit sat,
                                  output logic [2*L-1:0] o, output logic add);
        int h, li, ri;
        logic [L-1:0] lv, rv, res;
        logic [3:0] rc;
        longint s;
        h  = n / 2;
        li = h - 1;
        ri = h;
        for (int i = h - 1; i >= 0; i--) if (bus[i*L + L - 1]) li = i;
        for (int j = h; j < n; j++) if (bus[j*L + L - 1]) ri = j;
        lv  = bus[li*L +: L];
        rv  = bus[ri*L +: L];
        add = lv[40] && rv[40] && (lv[36:32] == rv[36:32]);
        if (!add) begin
            o = {rv, lv};
            return;
        end
        s = longint'($signed(lv[31:0])) + longint'($signed(rv[31:0]));
        if (sat && s > 64'sd2147483647) s = 64'sd2147483647;
        if (sat && s < -64'sd2147483648) s = -64'sd2147483648;
        if (lv[37] && rv[38]) rc = 4'b0100;
        else if (lv[37])      rc = 4'b1001;
        else if (rv[38])      rc = 4'b1010;
        else                  rc = 4'b1000;
        res = {rc, lv[36:32], s[31:0]};
        if (rc == 4'b1001)      o = {res, {L{1'b0}}};
        else if (rc == 4'b1010) o = {{L{1'b0}}, res};
        else                    o = {res, res};
    endfunction

    // Scoreboard for u0: compare every accepted output.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst0 && ov0 === 1'b1 && rdy0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL u0_unexpected_output got %h expected none", out0);
            end else begin
                e = q0.pop_front();
                if (e.add) exp_cnt0++;
                if (out0 !== e.o || cnt0 !== 16'(exp_cnt0)) begin
                    errors++;
                    $display("FAIL u0_scoreboard out=%h cnt=%0d expected out=%h cnt=%0d", out0, cnt0, e.o, exp_cnt0);
                end
            end
        end
    end

    // Scoreboard for u1: compare every accepted output.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst1 && ov1 === 1'b1 && rdy1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL u1_unexpected_output got %h expected none", out1);
            end else begin
                e = q1.pop_front();
                if (e.add) exp_cnt1++;
                if (out1 !== e.o || cnt1 !== 16'(exp_cnt1)) begin
                    errors++;
                    $display("FAIL u1_scoreboard out=%h cnt=%0d expected out=%h cnt=%0d", out1, cnt1, e.o, exp_cnt1);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send0(input logic [8*L-1:0] bus);
        exp_t e;
        int n = 0;
        iv0 = 1'b1;
        in0 = bus[2*L-1:0];
        @(negedge clk);
        while (!ir0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir0) begin
            checks++;
            errors++;
            $display("FAIL send0_timeout in_ready=%b expected 1", ir0);
        end else begin
            model(bus, 2, 1'b0, e.o, e.add);
            q0.push_back(e);
        end
        step();
        iv0 = 1'b0;
    endtask

    task automatic send1(input logic [8*L-1:0] bus);
        exp_t e;
        int n = 0;
        iv1 = 1'b1;
        in1 = bus;
        @(negedge clk);
        while (!ir1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir1) begin
            checks++;
            errors++;
            $display("FAIL send1_timeout in_ready=%b expected 1", ir1);
        end else begin
            model(bus, 8, 1'b1, e.o, e.add);
            q1.push_back(e);
        end
        step();
        iv1 = 1'b0;
    endtask

    task automatic test_reset;
        rst0 = 1'b1; rst1 = 1'b1; iv0 = 1'b0; iv1 = 1'b0;
        rdy0 = 1'b1; rdy1 = 1'b1; in0 = '0; in1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        checks++;
        if (ov0 !== 1'b0 || out0 !== '0 || cnt0 !== '0 || ir0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_u0 ov=%b out=%h cnt=%0d ir=%b expected 0/0/0/1", ov0, out0, cnt0, ir0);
        end
        checks++;
        if (ov1 !== 1'b0 || out1 !== '0 || cnt1 !== '0 || ir1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_u1 ov=%b out=%h cnt=%0d ir=%b expected 0/0/0/1", ov1, out1, cnt1, ir1);
        end
        step();
    endtask

    task automatic test_add_basic;
        logic [8*L-1:0] bus = '0;
        logic [L-1:0] r;
        bus[0 +: L] = mkline(4'b1001, 5'd3, 32'd5);
        bus[L +: L] = mkline(4'b1010, 5'd3, 32'd7);
        r = mkline(4'b0100, 5'd3, 32'd12);
        send0(bus);
        @(negedge clk);
        checks++;
        if (ov0 !== 1'b1 || out0 !== {r, r} || cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL add_done ov=%b out=%h cnt=%0d expected 1 %h 1", ov0, out0, cnt0, {r, r});
        end
        step();
    endtask

    task automatic test_forward;
        logic [8*L-1:0] bus = '0;
        logic [L-1:0] l, r;
        l = mkline(4'b1001, 5'd2, 32'd4);
        r = mkline(4'b1000, 5'd5, 32'd9);
        bus[0 +: L] = l;
        bus[L +: L] = r;
        send0(bus);
        @(negedge clk);
        checks++;
        if (out0 !== {r, l} || cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL forward out=%h cnt=%0d expected %h 1", out0, cnt0, {r, l});
        end
        step();
    endtask

    task automatic test_wrap_sat;
        logic [8*L-1:0] bus = '0;
        logic [L-1:0] w, s;
        bus[0 +: L] = mkline(4'b1000, 5'd1, 32'h7FFF_FFF0);
        bus[L +: L] = mkline(4'b1000, 5'd1, 32'h0000_0020);
        w = mkline(4'b1000, 5'd1, 32'h8000_0010);
        send0(bus);
        @(negedge clk);
        checks++;
        if (out0 !== {w, w} || cnt0 !== 16'd2) begin
            errors++;
            $display("FAIL wrap_add out=%h cnt=%0d expected %h 2", out0, cnt0, {w, w});
        end
        step();
        bus = '0;
        bus[3*L +: L] = mkline(4'b1000, 5'd1, 32'h7FFF_FFF0);
        bus[4*L +: L] = mkline(4'b1000, 5'd1, 32'h0000_0020);
        s = mkline(4'b1000, 5'd1, 32'h7FFF_FFFF);
        send1(bus);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out1 !== {s, s}) begin
            errors++;
            $display("FAIL sat_add out=%h expected %h", out1, {s, s});
        end
        step();
        // Negative overflow clamps to the minimum value; the scoreboard checks it.
        bus[3*L +: L] = mkline(4'b1000, 5'd4, 32'h8000_0001);
        bus[4*L +: L] = mkline(4'b1000, 5'd4, 32'h8000_0001);
        send1(bus);
        repeat (2) step();
    endtask

    task automatic test_mux8_latency;
        logic [8*L-1:0] bus = '0;
        logic [L-1:0] r;
        bus[0*L +: L] = mkline(4'b0000, 5'd7, 32'd99);
        bus[2*L +: L] = mkline(4'b1001, 5'd7, 32'd10);
        bus[5*L +: L] = mkline(4'b1000, 5'd7, 32'd20);
        bus[6*L +: L] = mkline(4'b0010, 5'd7, 32'd55);
        r = mkline(4'b1001, 5'd7, 32'd30);
        send1(bus);
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b0) begin
            errors++;
            $display("FAIL latency2_early out_valid=%b expected 0", ov1);
        end
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b1 || out1 !== {r, {L{1'b0}}}) begin
            errors++;
            $display("FAIL mux8_start_frag ov=%b out=%h expected 1 %h", ov1, out1, {r, {L{1'b0}}});
        end
        step();
        // No active line at all: the lines next to the centre are forwarded.
        bus = '0;
        bus[3*L +: L] = mkline(4'b0001, 5'd1, 32'd33);
        bus[4*L +: L] = mkline(4'b0010, 5'd1, 32'd44);
        send1(bus);
        repeat (3) step();
    endtask

    task automatic test_stall;
        logic [8*L-1:0] a = '0, b = '0, c = '0, d = '0;
        logic [2*L-1:0] ea;
        logic ead;
        int t;
        a[0 +: L] = mkline(4'b1000, 5'd6, 32'd100);
        a[L +: L] = mkline(4'b1000, 5'd6, 32'd1);
        b[0 +: L] = mkline(4'b1001, 5'd2, 32'd11);
        b[L +: L] = mkline(4'b1010, 5'd2, 32'd22);
        c[0 +: L] = mkline(4'b1000, 5'd1, 32'd3);
        c[L +: L] = mkline(4'b1010, 5'd1, 32'd4);
        d[0 +: L] = mkline(4'b1000, 5'd1, 32'd5);
        d[L +: L] = mkline(4'b1000, 5'd2, 32'd6);
        model(a, 2, 1'b0, ea, ead);
        send0(a);
        rdy0 = 1'b0;
        fork
            send0(b);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (ir0 !== 1'b0 || ov0 !== 1'b1 || out0 !== ea) begin
                        errors++;
                        $display("FAIL stall_hold ir=%b ov=%b out=%h expected 0 1 %h", ir0, ov0, out0, ea);
                    end
                end
                step();
                rdy0 = 1'b1;
            end
        join
        t = cyc;
        send0(c);
        send0(d);
        checks++;
        if (cyc - t != 2) begin
            errors++;
            $display("FAIL back_to_back cycles=%0d expected 2", cyc - t);
        end
        repeat (2) step();
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL stall_drain pending=%0d expected 0", q0.size());
        end
    endtask

    task automatic test_reset_inflight;
        logic [8*L-1:0] a = '0;
        a[1*L +: L] = mkline(4'b1000, 5'd9, 32'd1);
        a[6*L +: L] = mkline(4'b1000, 5'd9, 32'd2);
        send1(a);
        send1(a);
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        q1.delete();
        exp_cnt1 = 0;
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b0 || cnt1 !== 16'd0 || out1 !== '0) begin
            errors++;
            $display("FAIL reset_inflight ov=%b cnt=%0d out=%h expected 0 0 0", ov1, cnt1, out1);
        end
        step();
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dropped out_valid=%b expected 0", ov1);
        end
        step();
    endtask

    function automatic logic [L-1:0] rand_line(input int act_pct);
        logic [31:0] dv;
        case ($urandom_range(0, 3))
            0:       dv = 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
            1:       dv = 32'h8000_0000 + 32'($urandom_range(0, 31));
            default: dv = $urandom;
        endcase
        return {($urandom_range(0, 99) < act_pct), 3'($urandom), 5'($urandom_range(0, 2)), dv};
    endfunction

    task automatic test_random;
        bit done0 = 0, done1 = 0;
        fork
            begin
                logic [8*L-1:0] bus;
                for (int k = 0; k < 60; k++) begin
                    bus = '0;
                    for (int i = 0; i < 2; i++) bus[i*L +: L] = rand_line(75);
                    send0(bus);
                end
                done0 = 1;
            end
            begin
                while (!done0) begin
                    step();
                    rdy0 = ($urandom_range(0, 3) != 0);
                end
                rdy0 = 1'b1;
            end
            begin
                logic [8*L-1:0] bus;
                for (int k = 0; k < 60; k++) begin
                    bus = '0;
                    for (int i = 0; i < 8; i++) bus[i*L +: L] = rand_line(30);
                    send1(bus);
                end
                done1 = 1;
            end
            begin
                while (!done1) begin
                    step();
                    rdy1 = ($urandom_range(0, 2) != 0);
                end
                rdy1 = 1'b1;
            end
        join
        repeat (6) step();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL random_drain pending=%0d/%0d expected 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_forward();
        test_wrap_sat();
        test_mux8_latency();
        test_stall();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
